// File: rtl/andor_sweep_checker.sv
// Clocked exhaustive tester for a WIDTH-bit AND/OR gate stage: steps every A/B
// combination, checks the gate's AND/OR outputs, and reports error count, first failure and pass.
module andor_sweep_checker #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic [WIDTH-1:0]   and_in,
  input  logic [WIDTH-1:0]   or_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [2*WIDTH-1:0] fail_idx
);

  localparam int IDX_W = 2 * WIDTH;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = '1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    sIdle,
    sDrive,
    sSettle,
    sCheck,
    sDone
  } stateT;

  stateT            state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] waitCnt;

  function automatic logic vecMismatch(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] andObs,
    input logic [WIDTH-1:0] orObs
  );
    return ((a & b) != andObs) || ((a | b) != orObs);
  endfunction

  logic curMismatch;
  assign curMismatch = vecMismatch(a_out, b_out, and_in, or_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= sIdle;
      idx       <= '0;
      waitCnt   <= '0;
      a_out     <= '0;
      b_out     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_idx  <= '0;
    end else begin
      case (state)
        // DONE accepts a restart exactly like IDLE; start is ignored everywhere else.
        sIdle, sDone: begin
          if (start) begin
            idx       <= '0;
            err_count <= '0;
            fail_idx  <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            state     <= sDrive;
          end
        end
        sDrive: begin
          a_out   <= idx[IDX_W-1:WIDTH];
          b_out   <= idx[WIDTH-1:0];
          waitCnt <= '0;
          state   <= sSettle;
        end
        sSettle: begin
          if (waitCnt == SETTLE_LAST) begin
            state <= sCheck;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        sCheck: begin
          if (curMismatch) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0) begin
              fail_idx <= idx;
            end
          end
          // Pass must account for the vector being checked on this same edge.
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !curMismatch;
            state <= sDone;
          end else begin
            idx   <= idx + 1'b1;
            state <= sDrive;
          end
        end
        default: state <= sIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_andor_sweep_checker.sv
// Randomized scoreboard bench for andor_sweep_checker with a faultable gate model.
module tb_andor_sweep_checker;

  localparam int W     = 2;
  localparam int S     = 2;
  localparam int NV    = 1 << (2 * W);
  localparam int PER   = S + 2;
  localparam int SWEEP = NV * PER;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a_out, b_out, and_in, or_in;
  logic           busy, done, pass;
  logic [2*W:0]   err_count;
  logic [2*W-1:0] fail_idx;

  int faultMode = 0;
  int faultVec  = 0;
  int edgeNum   = 0;
  int checks    = 0;
  int failures  = 0;
  bit hold      = 1'b0;

  typedef struct {
    int acceptEdge;
    int doneEdge;
    int errs;
    int firstIdx;
    bit passExp;
  } sweepT;

  sweepT sb[$];

  andor_sweep_checker #(.WIDTH(W), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_out(a_out), .b_out(b_out), .and_in(and_in), .or_in(or_in),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_idx(fail_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edgeNum <= edgeNum + 1;

  // Gate under test, with selectable faults.
  always_comb begin
    and_in = a_out & b_out;
    or_in  = a_out | b_out;
    case (faultMode)
      1: and_in[0] = 1'b1;
      2: begin
        and_in = a_out | b_out;
        or_in  = a_out & b_out;
      end
      3: if ({a_out, b_out} == faultVec[2*W-1:0]) or_in[0] = ~or_in[0];
      default: ;
    endcase
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edgeNum);
    end
  endtask

  // Which vectors fail for a fault mode, from the fault's definition.
  function automatic void modelSweep(input int mode, input int fv,
                                     output int errs, output int first);
    errs  = 0;
    first = 0;
    for (int k = 0; k < NV; k++) begin
      int a, b;
      bit bad;
      a = k / (1 << W);
      b = k % (1 << W);
      case (mode)
        1: bad = ((a & b) % 2) == 0;
        2: bad = (a != b);
        3: bad = (k == fv);
        default: bad = 1'b0;
      endcase
      if (bad) begin
        if (errs == 0) first = k;
        errs++;
      end
    end
  endfunction

  task automatic checkReset(input string tag);
    chk({tag, ".a_out"}, a_out, 0);
    chk({tag, ".b_out"}, b_out, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pass"}, pass, 0);
    chk({tag, ".err_count"}, err_count, 0);
    chk({tag, ".fail_idx"}, fail_idx, 0);
  endtask

  // Monitor: vector stepping, busy window and final results against the scoreboard.
  initial begin : monitor
    bit    prevDone;
    bit    act;
    int    off;
    int    k;
    sweepT e;
    prevDone = 1'b0;
    forever begin
      @(negedge clk);
      if (!hold) begin
        act = 1'b0;
        off = -1;
        if (sb.size() > 0) begin
          off = edgeNum - sb[0].acceptEdge;
          act = (off >= 0 && off < SWEEP);
        end
        chk("busy", busy, act);
        if (sb.size() > 0 && off >= 1 && off <= SWEEP) begin
          k = (off - 1) / PER;
          chk("a_out", a_out, k >> W);
          chk("b_out", b_out, k % (1 << W));
        end
        if (done === 1'b1 && !prevDone) begin
          if (sb.size() == 0) begin
            chk("doneUnexpected", done, 0);
          end else begin
            e = sb.pop_front();
            chk("doneEdge", edgeNum, e.doneEdge);
            chk("err_count", err_count, e.errs);
            chk("fail_idx", fail_idx, e.firstIdx);
            chk("pass", pass, e.passExp);
          end
        end
      end
      prevDone = (done === 1'b1);
    end
  end

  task automatic runSweep(input int mode, input int extraOff, input int rstOff);
    sweepT e;
    int    errs, first, off, guard;
    @(negedge clk);
    faultMode = mode;
    faultVec  = $urandom_range(NV - 1);
    modelSweep(mode, faultVec, errs, first);
    e.acceptEdge = edgeNum + 1;
    e.doneEdge   = e.acceptEdge + SWEEP;
    e.errs       = errs;
    e.firstIdx   = first;
    e.passExp    = (errs == 0);
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("startDone", done, 0);
    chk("startErr", err_count, 0);
    chk("startFail", fail_idx, 0);
    chk("startPass", pass, 0);
    guard = 0;
    while (sb.size() > 0 && guard < SWEEP + 20) begin
      off   = edgeNum - e.acceptEdge;
      start = (extraOff > 0 && off == extraOff - 1);
      if (rstOff > 0 && off == rstOff - 1) begin
        hold  = 1'b1;
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        checkReset("midRst");
        hold = 1'b0;
        return;
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    if (sb.size() > 0) begin
      chk("sweepTimeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin : stimulus
    rst   = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    checkReset("rst");
    rst   = 1'b0;
    start = 1'b0;

    runSweep(0, 20, 0);   // clean sweep with an ignored start at edge 20
    runSweep(0, 0, 0);    // restart from DONE
    runSweep(1, 0, 0);    // and_in[0] stuck at 1
    runSweep(2, 0, 0);    // swapped buses
    runSweep(3, 0, 0);    // single corrupted vector
    runSweep(0, 0, 22);   // reset during vector 5
    runSweep(0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      int m, ex, ro;
      repeat ($urandom_range(4)) @(negedge clk);
      m  = $urandom_range(3);
      ex = ($urandom_range(1) == 1) ? $urandom_range(SWEEP - 1, 2) : 0;
      ro = ($urandom_range(3) == 0) ? $urandom_range(SWEEP - 1, 2) : 0;
      runSweep(m, ex, ro);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edgeNum);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/andor_sweep_checker.md
# andor_sweep_checker

Self-checking stimulus/response sequencer wrapped around the 2-bit AND/OR gate stage. It drives the gate's `A`/`B` inputs and reads back its `AandB`/`AorB` outputs. It replaces the free-running delay-based tester with a clocked, exhaustive sweep of every input combination. Each result is compared against the expected AND/OR values, and the block reports the error count, the first failing vector and a pass/fail flag.

## Interface
- `WIDTH`, default 2: operand width; must match the gate stage.
- `SETTLE`, default 2: cycles between driving a vector and sampling the response; legal range ≥1.
- `clk`  in  1: sole clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: sweep request; sampled only in IDLE or DONE.
- `a_out`  out  WIDTH: drives gate input `A`.
- `b_out`  out  WIDTH: drives gate input `B`.
- `and_in`  in  WIDTH: gate output `AandB`.
- `or_in`  in  WIDTH: gate output `AorB`.
- `busy`  out  1: high while a sweep is in progress.
- `done`  out  1: high from sweep completion until the next accepted `start` or `rst`.
- `pass`  out  1: valid when `done`=1; high iff `err_count`==0.
- `err_count`  out  2*WIDTH+1: number of failing vectors in the current or last sweep.
- `fail_idx`  out  2*WIDTH: index of the first failing vector; 0 if none.

## Operation
- **Vector index.** `idx` is 2*WIDTH bits, N = 2^(2*WIDTH) vectors. Vector k drives `a_out`=k[2W-1:W] and `b_out`=k[W-1:0].
- **States:** IDLE, DRIVE, SETTLE, CHECK, DONE.
- **IDLE.** On `start`=1:
  - `idx`←0, `err_count`←0, `fail_idx`←0, `done`←0, `pass`←0, `busy`←1.
  - Next state DRIVE.
- **DRIVE** (1 cycle):
  - `a_out`/`b_out` ← fields of `idx`; wait counter ←0.
  - Next state SETTLE.
- **SETTLE** (exactly `SETTLE` cycles):
  - Wait counter increments each cycle.
  - Leave for CHECK on the cycle the counter equals `SETTLE`-1.
- **CHECK** (1 cycle):
  - Expected values: `a_out & b_out` for `and_in`, `a_out | b_out` for `or_in`.
  - Mismatch on either bus:
    - `err_count` increments.
    - If `err_count` was 0, `fail_idx`←`idx`.
  - If `idx`==N-1: next state DONE, with `busy`←0, `done`←1 and `pass`←(no errors including this vector).
  - Otherwise: `idx`←`idx`+1, next state DRIVE.
- **DONE:**
  - All results are held and `a_out`/`b_out` hold the last vector.
  - `start`=1 restarts exactly as from IDLE, clearing the results in the same edge.
- **`start` while busy:** ignored. It is not queued.
- **Counter width.** `err_count` has enough width for N errors; it never saturates or wraps.
- **`idx` wrap.** `idx` never wraps; the sweep terminates at N-1.
- **Reset.** `rst` has priority over all other inputs in every state, including mid-sweep. Next edge:
  - State IDLE.
  - `a_out`=0, `b_out`=0.
  - `busy`=0, `done`=0, `pass`=0.
  - `err_count`=0, `fail_idx`=0.
  - All internal counters 0.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Edge 0 is the edge that samples `start`.
- Vector k (0-based):
  - Driven on edge 1+k·(SETTLE+2).
  - Sampled on edge (k+1)·(SETTLE+2).
  - So the gate has `SETTLE`+1 full cycles to settle.
- `done` rises, and `busy` falls, on edge N·(SETTLE+2).
  - WIDTH=2, SETTLE=2 gives edge 64.
- `busy` rises on edge 0.
- Restart from DONE: `done` drops on edge 0 of the new sweep.

## Test plan
- **Reset values.** Assert `rst` 2 cycles with `start`=1 → all outputs 0 and `busy` stays 0.
- **Clean sweep.** Correct gate connected, WIDTH=2, SETTLE=2, 1-cycle `start` pulse:
  - `a_out`/`b_out` step 00/00, 00/01 … 11/11, each held 4 cycles.
  - `done`=1 on edge 64, with `pass`=1, `err_count`=0, `fail_idx`=0.
- **Stuck-at on `and_in[0]`** (forced to 1) → `done` on edge 64, `err_count`=12, `fail_idx`=0, `pass`=0.
- **Swapped buses** (`and_in`←gate OR output, `or_in`←gate AND output) → `err_count`=12, `fail_idx`=1, `pass`=0.
- **`start` while busy.**
  - Pulse `start` again at edge 20 → ignored; `done` still on edge 64.
  - Pulse `start` in DONE → `done`/`err_count` clear the next edge and the sweep repeats with identical results.
- **Mid-sweep reset.** Assert `rst` during vector 5 (edge 22) for 1 cycle:
  - Next edge: IDLE with all reset values.
  - A subsequent `start` gives a full 64-cycle sweep with `pass`=1.
